// File: rtl/peripheral_lvds_rx_pkg.sv
// Shared constants and types for the LVDS receive peripheral.
package peripheral_lvds_rx_pkg;

    localparam int WORD_BITS = 7;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_DATA1  = 4'h2;
    localparam logic [3:0] ADDR_DATA2  = 4'h4;
    localparam logic [3:0] ADDR_DATA3  = 4'h6;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam logic [WORD_BITS-1:0] CLK_PATTERN = 7'b1111000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic [WORD_BITS-1:0] ch1;
        logic [WORD_BITS-1:0] ch2;
        logic [WORD_BITS-1:0] ch3;
    } frame_t;

endpackage

// File: rtl/lvds_rx_deser.sv
// Deserialiser: synchronises the serial inputs, aligns on the frame-clock rising
// edge, shifts one word per channel and validates the forwarded clock pattern.
module lvds_rx_deser
    import peripheral_lvds_rx_pkg::*;
#(
    parameter int BIT_DIV   = 8,
    parameter int WORD_BITS = peripheral_lvds_rx_pkg::WORD_BITS
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    input  logic   channel1_i,
    input  logic   channel2_i,
    input  logic   channel3_i,
    input  logic   clock_i,
    output frame_t frame,
    output logic   commit,
    output logic   err
);

    localparam int PH_W   = $clog2(BIT_DIV);
    localparam int CNT_W  = $clog2(WORD_BITS);
    localparam int CH_CLK = 3;
    localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(BIT_DIV / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WORD_BITS - 1);

    logic [3:0]                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic                       clk_prev_q, clk_prev_d;
    logic                       frame_start;
    rx_state_e                  state_q, state_d;
    logic [PH_W-1:0]            phase_q, phase_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0][WORD_BITS-1:0]  sh_q, sh_d;
    logic                       commit_q, commit_d, err_q, err_d;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        sync1_d     = {clock_i, channel3_i, channel2_i, channel1_i};
        sync2_d     = sync1_q;
        clk_prev_d  = sync2_q[CH_CLK];
        frame_start = sync2_q[CH_CLK] & ~clk_prev_q;
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        commit_d    = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && frame_start) begin
                    state_d   = ST_SHIFT;
                    phase_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (phase_q == PH_SAMPLE) begin
                        for (int i = 0; i < 4; i++) begin
                            sh_d[i] = {sh_q[i][WORD_BITS-2:0], sync2_q[i]};
                        end
                    end
                    if (phase_q == PH_LAST) begin
                        phase_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            // The last sample is already in sh_q, so the verdict is
                            // registered here and presented during the CHECK cycle.
                            state_d  = ST_CHECK;
                            commit_d = (sh_q[CH_CLK] == CLK_PATTERN);
                            err_d    = (sh_q[CH_CLK] != CLK_PATTERN);
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            ST_CHECK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            clk_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            commit_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            clk_prev_q <= clk_prev_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            commit_q   <= commit_d;
            err_q      <= err_d;
        end
    end

    assign frame  = '{ch1: sh_q[0], ch2: sh_q[1], ch3: sh_q[2]};
    assign commit = commit_q;
    assign err    = err_q;

endmodule

// File: rtl/peripheral_lvds_rx.sv
// LVDS receive peripheral on the 16-bit I/O bus: frame registers, status flags, control.
// Optional interrupt output enabled by defining LVDS_RX_IRQ_EN.
module peripheral_lvds_rx
    import peripheral_lvds_rx_pkg::*;
#(
    parameter int BIT_DIV   = 8,
    parameter int WORD_BITS = peripheral_lvds_rx_pkg::WORD_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        channel1_i,
    input  logic        channel2_i,
    input  logic        channel3_i,
    input  logic        clock_i
`ifdef LVDS_RX_IRQ_EN
    ,
    output logic        irq
`endif
);

    frame_t frame, data_q, data_d;
    logic   commit, err;
    logic   valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic   enable_q, enable_d;
    logic   wr_en, rd_en;
    logic   unused_bits;
`ifdef LVDS_RX_IRQ_EN
    logic   irq_en_q, irq_en_d, irq_q, irq_d;
`endif

    lvds_rx_deser #(
        .BIT_DIV   (BIT_DIV),
        .WORD_BITS (WORD_BITS)
    ) u_deser (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable_q),
        .channel1_i (channel1_i),
        .channel2_i (channel2_i),
        .channel3_i (channel3_i),
        .clock_i    (clock_i),
        .frame      (frame),
        .commit     (commit),
        .err        (err)
    );

    assign wr_en       = cs & wr;
    assign rd_en       = cs & rd;
    assign unused_bits = ^d_in[15:3];

    // Clears are applied first so a same-cycle commit or error overrides them.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        enable_d    = enable_q;
        if (wr_en && addr == ADDR_STATUS) begin
            if (d_in[1]) overrun_d   = 1'b0;
            if (d_in[2]) frame_err_d = 1'b0;
        end
        if (wr_en && addr == ADDR_CTRL) enable_d = d_in[0];
        if (rd_en && addr == ADDR_DATA3) valid_d = 1'b0;
        if (commit) begin
            data_d  = frame;
            valid_d = 1'b1;
            if (valid_q) overrun_d = 1'b1;
        end
        if (err) frame_err_d = 1'b1;
    end

`ifdef LVDS_RX_IRQ_EN
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && addr == ADDR_CTRL) irq_en_d = d_in[1];
        irq_d = irq_en_q & (valid_q | overrun_q | frame_err_q);
    end
`endif

    always_comb begin
        d_out = 16'h0000;
        if (rd_en) begin
            case (addr)
                ADDR_STATUS: d_out = {13'b0, frame_err_q, overrun_q, valid_q};
                ADDR_DATA1:  d_out = {9'b0, data_q.ch1};
                ADDR_DATA2:  d_out = {9'b0, data_q.ch2};
                ADDR_DATA3:  d_out = {9'b0, data_q.ch3};
`ifdef LVDS_RX_IRQ_EN
                ADDR_CTRL:   d_out = {14'b0, irq_en_q, enable_q};
`else
                ADDR_CTRL:   d_out = {15'b0, enable_q};
`endif
                default:     d_out = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            enable_q    <= enable_d;
        end
    end

`ifdef LVDS_RX_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_peripheral_lvds_rx.sv
// Self-checking bench for peripheral_lvds_rx: directed vector table, timed corner
// sequences and randomized frames against a frame-level register model.
module tb_peripheral_lvds_rx;

    localparam int         BIT_DIV  = 8;
    localparam logic [3:0] A_STATUS = 4'h0;
    localparam logic [3:0] A_DATA1  = 4'h2;
    localparam logic [3:0] A_DATA2  = 4'h4;
    localparam logic [3:0] A_DATA3  = 4'h6;
    localparam logic [3:0] A_CTRL   = 4'h8;
    localparam logic [6:0] GOOD     = 7'b1111000;
    localparam logic [6:0] BAD      = 7'b1110000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [15:0] d_in = 16'h0000;
    logic [15:0] d_out;
    logic        ch1 = 1'b0, ch2 = 1'b0, ch3 = 1'b0, fclk = 1'b0;
`ifdef LVDS_RX_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Register-level model, updated once per whole frame or bus access.
    logic       m_valid, m_ovr, m_ferr, m_en, m_irq_en;
    logic [6:0] m_d1, m_d2, m_d3;

    typedef struct {
        logic [6:0]  c1, c2, c3, pat;
        logic [15:0] st, d1, d2, w1c, st_w1c;
        logic        rd3;
        logic [15:0] d3, st_final;
    } vec_t;

    vec_t vecs [5];

    peripheral_lvds_rx #(.BIT_DIV(BIT_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .cs         (cs),
        .addr       (addr),
        .rd         (rd),
        .wr         (wr),
        .d_out      (d_out),
        .channel1_i (ch1),
        .channel2_i (ch2),
        .channel3_i (ch3),
        .clock_i    (fclk)
`ifdef LVDS_RX_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_en = 1'b0; m_irq_en = 1'b0;
        m_d1 = '0; m_d2 = '0; m_d3 = '0;
    endtask

    function automatic logic [15:0] model_reg(input logic [3:0] a);
        case (a)
            A_STATUS: return {13'b0, m_ferr, m_ovr, m_valid};
            A_DATA1:  return {9'b0, m_d1};
            A_DATA2:  return {9'b0, m_d2};
            A_DATA3:  return {9'b0, m_d3};
            A_CTRL:   return {14'b0, m_irq_en, m_en};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_frame(input logic [6:0] c1, c2, c3, pat);
        if (m_en) begin
            if (pat == GOOD) begin
                if (m_valid) m_ovr = 1'b1;
                m_valid = 1'b1;
                m_d1 = c1; m_d2 = c2; m_d3 = c3;
            end else begin
                m_ferr = 1'b1;
            end
        end
    endtask

    task automatic model_write(input logic [3:0] a, input logic [15:0] v);
        if (a == A_STATUS) begin
            if (v[1]) m_ovr  = 1'b0;
            if (v[2]) m_ferr = 1'b0;
        end else if (a == A_CTRL) begin
            m_en = v[0];
`ifdef LVDS_RX_IRQ_EN
            m_irq_en = v[1];
`endif
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
        model_write(a, v);
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [15:0] v);
        @(posedge clk); #1;
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        v = d_out;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        if (a == A_DATA3) m_valid = 1'b0;
    endtask

    task automatic check_reg(input logic [3:0] a, input logic [15:0] exp, input string name);
        logic [15:0] v;
        read_reg(a, v);
        check(name, v, exp);
    endtask

    task automatic check_model(input logic [3:0] a, input string name);
        logic [15:0] exp;
        logic [15:0] v;
        exp = model_reg(a);
        read_reg(a, v);
        check(name, v, exp);
    endtask

    // Drives one frame MSB first, BIT_DIV cycles per bit; returns 56 cycles after bit 0.
    task automatic send_frame(input logic [6:0] c1, c2, c3, pat);
        for (int b = 6; b >= 0; b--) begin
            ch1 = c1[b]; ch2 = c2[b]; ch3 = c3[b]; fclk = pat[b];
            repeat (BIT_DIV) @(posedge clk);
            #1;
        end
        ch1 = 1'b0; ch2 = 1'b0; ch3 = 1'b0; fclk = 1'b0;
    endtask

    task automatic rx_frame(input logic [6:0] c1, c2, c3, pat);
        send_frame(c1, c2, c3, pat);
        repeat (2 * BIT_DIV) @(posedge clk);
        #1;
        model_frame(c1, c2, c3, pat);
    endtask

    initial begin
        logic [6:0]  r1, r2, r3, rp;
        logic [15:0] w;
        int          r;

        vecs[0] = '{7'h55, 7'h2A, 7'h7F, GOOD, 16'h0001, 16'h0055, 16'h002A, 16'h0000, 16'h0000, 1'b1, 16'h007F, 16'h0000};
        vecs[1] = '{7'h11, 7'h22, 7'h33, GOOD, 16'h0001, 16'h0011, 16'h0022, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[2] = '{7'h44, 7'h55, 7'h66, GOOD, 16'h0003, 16'h0044, 16'h0055, 16'h0002, 16'h0001, 1'b1, 16'h0066, 16'h0000};
        vecs[3] = '{7'h01, 7'h02, 7'h03, BAD,  16'h0004, 16'h0044, 16'h0055, 16'h0004, 16'h0000, 1'b1, 16'h0066, 16'h0000};
        vecs[4] = '{7'h7F, 7'h00, 7'h5A, GOOD, 16'h0001, 16'h007F, 16'h0000, 16'h0006, 16'h0001, 1'b1, 16'h005A, 16'h0000};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("d_out idle after reset", d_out, 16'h0000);
        check_reg(A_STATUS, 16'h0000, "reset status");
        check_reg(A_DATA1,  16'h0000, "reset data1");
        check_reg(A_DATA3,  16'h0000, "reset data3");
        check_reg(A_CTRL,   16'h0000, "reset ctrl");

        bus_write(A_CTRL, 16'h0001);
        check_reg(A_CTRL, 16'h0001, "ctrl enable readback");

        for (int i = 0; i < 5; i++) begin
            rx_frame(vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].pat);
            check_reg(A_STATUS, vecs[i].st, $sformatf("vec%0d status", i));
            check_reg(A_DATA1,  vecs[i].d1, $sformatf("vec%0d data1", i));
            check_reg(A_DATA2,  vecs[i].d2, $sformatf("vec%0d data2", i));
            if (vecs[i].w1c != 16'h0000) begin
                bus_write(A_STATUS, vecs[i].w1c);
                check_reg(A_STATUS, vecs[i].st_w1c, $sformatf("vec%0d status after w1c", i));
            end
            if (vecs[i].rd3) begin
                check_reg(A_DATA3,  vecs[i].d3,       $sformatf("vec%0d data3", i));
                check_reg(A_STATUS, vecs[i].st_final, $sformatf("vec%0d status after data3 read", i));
            end
        end

        // Disabled receiver ignores a complete frame.
        bus_write(A_CTRL, 16'h0000);
        rx_frame(7'h12, 7'h34, 7'h56, GOOD);
        check_reg(A_STATUS, 16'h0000, "disabled status");
        check_reg(A_DATA1,  16'h007F, "disabled data1 kept");

        // Enable dropped after three bits aborts the frame.
        bus_write(A_CTRL, 16'h0001);
        fork
            send_frame(7'h21, 7'h43, 7'h65, GOOD);
            begin
                repeat (3 * BIT_DIV) @(posedge clk);
                #1;
                bus_write(A_CTRL, 16'h0000);
            end
        join
        repeat (2 * BIT_DIV) @(posedge clk);
        #1;
        check_reg(A_STATUS, 16'h0000, "abort status");
        check_reg(A_DATA1,  16'h007F, "abort data1 kept");
        bus_write(A_CTRL, 16'h0001);
        rx_frame(7'h3C, 7'h0F, 7'h70, GOOD);
        check_reg(A_STATUS, 16'h0001, "after abort status");
        check_reg(A_DATA1,  16'h003C, "after abort data1");
        check_reg(A_DATA2,  16'h000F, "after abort data2");
        check_reg(A_DATA3,  16'h0070, "after abort data3");

        // DATA3 read strobed in the commit cycle: the commit must win.
        send_frame(7'h2A, 7'h15, 7'h63, GOOD);
        repeat (3) @(posedge clk);
        #1;
        cs = 1'b1; rd = 1'b1; addr = A_DATA3;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        m_valid = 1'b0;
        model_frame(7'h2A, 7'h15, 7'h63, GOOD);
        check_reg(A_STATUS, 16'h0001, "collision status");
        check_reg(A_DATA1,  16'h002A, "collision data1");
        check_reg(A_DATA3,  16'h0063, "collision data3");

        // Reset pulse during bit 4 of a frame.
        fork
            send_frame(7'h0A, 7'h0B, 7'h0C, GOOD);
            begin
                repeat (4 * BIT_DIV) @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        repeat (2 * BIT_DIV) @(posedge clk);
        #1;
        model_reset();
        check_reg(A_STATUS, 16'h0000, "midreset status");
        check_reg(A_DATA1,  16'h0000, "midreset data1");
        check_reg(A_DATA2,  16'h0000, "midreset data2");
        check_reg(A_DATA3,  16'h0000, "midreset data3");
        check_reg(A_CTRL,   16'h0000, "midreset ctrl");
`ifdef LVDS_RX_IRQ_EN
        bus_write(A_CTRL, 16'h0003);
        send_frame(7'h6B, 7'h1D, 7'h4E, GOOD);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("irq low in commit cycle", {15'b0, irq}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check("irq high after commit", {15'b0, irq}, 16'h0001);
        repeat (2 * BIT_DIV) @(posedge clk);
        #1;
        model_frame(7'h6B, 7'h1D, 7'h4E, GOOD);
`else
        bus_write(A_CTRL, 16'h0001);
        rx_frame(7'h6B, 7'h1D, 7'h4E, GOOD);
`endif
        check_reg(A_STATUS, 16'h0001, "post-reset status");
        check_reg(A_DATA1,  16'h006B, "post-reset data1");
        check_reg(A_DATA2,  16'h001D, "post-reset data2");
        check_reg(A_DATA3,  16'h004E, "post-reset data3");

        // Randomized frames against the register model.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                w = 16'($urandom);
                w[0] = (r != 0);
                bus_write(A_CTRL, w);
            end
            r1 = 7'($urandom); r2 = 7'($urandom); r3 = 7'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                rp = GOOD;
            end else begin
                rp = {1'b1, 6'($urandom)};
                if (rp == GOOD) rp = BAD;
            end
            rx_frame(r1, r2, r3, rp);
            if ($urandom_range(0, 2) == 0) begin
                w = 16'($urandom);
                bus_write(A_STATUS, w);
            end
            check_model(A_STATUS, $sformatf("rand%0d status", i));
            check_model(A_DATA1,  $sformatf("rand%0d data1", i));
            check_model(A_DATA2,  $sformatf("rand%0d data2", i));
            if ($urandom_range(0, 1) == 1) check_model(A_DATA3, $sformatf("rand%0d data3", i));
            if ($urandom_range(0, 3) == 0) check_model(4'($urandom_range(9, 15)), $sformatf("rand%0d unmapped", i));
            check_model(A_CTRL, $sformatf("rand%0d ctrl", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
